// File: rtl/uart_tx.sv
// uart_tx: pushes bytes into an AXI-Lite UART TX FIFO, polling status until there is room
module uart_tx #(
  parameter logic [3:0] TX_ADDR   = 4'h4,
  parameter logic [3:0] STAT_ADDR = 4'h8,
  parameter int         POLL_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [3:0]  araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [7:0]  rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, STAT_AR, STAT_R, GAP, WRITE, RESP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [15:0] gap_q, gap_d;
  logic        unused;
  assign unused  = ^{rdata[7:4], rdata[2:0], rresp[0], bresp[0]};
  assign ready   = state_q == IDLE;
  assign arvalid = state_q == STAT_AR;
  assign araddr  = arvalid ? STAT_ADDR : 4'h0;
  assign rready  = state_q == STAT_R;
  assign awvalid = state_q == WRITE && !aw_done_q;
  assign wvalid  = state_q == WRITE && !w_done_q;
  assign awaddr  = awvalid ? TX_ADDR : 4'h0;
  assign wdata   = {24'h0, byte_q};
  assign wstrb   = state_q == WRITE ? 4'b0001 : 4'b0000;
  assign bready  = state_q == RESP;
  assign done    = bready && bvalid && !bresp[1];
  assign err     = bready && bvalid && bresp[1];
  // state, latched byte, write-handshake flags and poll gap counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      byte_q    <= 8'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      gap_q     <= 16'h0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      gap_q     <= gap_d;
    end
  end
  // next state; flags collect each write handshake and clear once both are seen
  always_comb begin
    state_d   = state_q;
    byte_d    = (state_q == IDLE && valid) ? data : byte_q;
    gap_d     = state_q == GAP ? gap_q + 16'd1 : 16'd0;
    aw_done_d = state_q == WRITE && !(aw_done_q && w_done_q) && (aw_done_q || awready);
    w_done_d  = state_q == WRITE && !(aw_done_q && w_done_q) && (w_done_q || wready);
    case (state_q)
      IDLE:    state_d = valid ? STAT_AR : IDLE;
      STAT_AR: state_d = arready ? STAT_R : STAT_AR;
      STAT_R:  state_d = !rvalid ? STAT_R :
                         !(rresp[1] || rdata[3]) ? WRITE :
                         POLL_GAP == 0 ? STAT_AR : GAP;
      GAP:     state_d = gap_q == 16'(POLL_GAP - 1) ? STAT_AR : GAP;
      WRITE:   state_d = (aw_done_q && w_done_q) ? RESP : WRITE;
      RESP:    state_d = bvalid ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
endmodule
